// File: rtl/mips_pipe_core.sv
// mips_pipe_core: 5-stage IF/ID/EX/MEM/WB integer pipeline with forwarding, load-use interlock and EX branch squash
// Ports: clk/rst_n (sync active-low); imem_addr/imem_rdata fetch port; dmem_addr/dmem_wdata/dmem_we/dmem_rdata data port;
//        dbg_addr/dbg_rdata register debug read; halted (sticky after HLT retires); instret (retired instruction count).
// Opcodes: ADD 0, SUB 1, AND 2, OR 3, SLT 4, MUL 5, LW 8, SW 9, ADDI 10, SUBI 11, SLTI 12, BNEQZ 13, BEQZ 14, HLT 63.
module mips_pipe_core #(
   parameter int XLEN    = 32,
   parameter int NREG    = 32,
   parameter int PC_W    = 10,
   parameter int DADDR_W = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [31:0]        imem_rdata,
   output logic [DADDR_W-1:0] dmem_addr,
   output logic [XLEN-1:0]    dmem_wdata,
   output logic               dmem_we,
   input  logic [XLEN-1:0]    dmem_rdata,
   input  logic [4:0]         dbg_addr,
   output logic [XLEN-1:0]    dbg_rdata,
   output logic               halted,
   output logic [31:0]        instret
);
   localparam int RW = $clog2(NREG);
   typedef enum logic [5:0] {
      OP_ADD = 6'd0, OP_SUB = 6'd1, OP_AND = 6'd2, OP_OR = 6'd3, OP_SLT = 6'd4, OP_MUL = 6'd5,
      OP_LW = 6'd8, OP_SW = 6'd9, OP_ADDI = 6'd10, OP_SUBI = 6'd11, OP_SLTI = 6'd12,
      OP_BNEQZ = 6'd13, OP_BEQZ = 6'd14, OP_HLT = 6'd63
   } op_t;
   logic [XLEN-1:0] rf [NREG];
   logic [PC_W-1:0] pc;
   logic            halt_seen;
   logic            ifid_v;
   logic [31:0]     ifid_ir;
   logic [PC_W-1:0] ifid_npc;
   logic            idex_v, idex_wr;
   op_t             idex_op;
   logic [RW-1:0]   idex_rs, idex_rt, idex_dst;
   logic [XLEN-1:0] idex_a, idex_b, idex_imm;
   logic [PC_W-1:0] idex_npc;
   logic            exmem_v, exmem_wr;
   op_t             exmem_op;
   logic [RW-1:0]   exmem_dst;
   logic [XLEN-1:0] exmem_res, exmem_b;
   logic            memwb_v, memwb_wr, memwb_hlt;
   logic [RW-1:0]   memwb_dst;
   logic [XLEN-1:0] memwb_res;
   op_t             id_op;
   logic [RW-1:0]   id_rs, id_rt, id_rd, id_dst;
   logic            id_rr, id_ri, id_wr, id_use_rt, hlt_id, ld_use, wb_wr;
   logic [XLEN-1:0] id_a, id_b, id_imm;
   logic            exmem_fwd, memwb_fwd, taken;
   logic [XLEN-1:0] ex_a, ex_b, op2, ex_res;
   logic [PC_W-1:0] target;
   // Decode; anything outside the ISA is treated as HLT
   assign id_op = (ifid_ir[31:26] inside {6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd9, 6'd10,
                                          6'd11, 6'd12, 6'd13, 6'd14}) ? op_t'(ifid_ir[31:26]) : OP_HLT;
   assign id_rs     = ifid_ir[21 +: RW];
   assign id_rt     = ifid_ir[16 +: RW];
   assign id_rd     = ifid_ir[11 +: RW];
   assign id_imm    = XLEN'($signed(ifid_ir[15:0]));
   assign id_rr     = id_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL};
   assign id_ri     = id_op inside {OP_ADDI, OP_SUBI, OP_SLTI};
   assign id_wr     = id_rr | id_ri | (id_op == OP_LW);
   assign id_dst    = id_rr ? id_rd : id_rt;
   assign id_use_rt = id_rr | (id_op == OP_SW);
   assign hlt_id    = ifid_v & (id_op == OP_HLT);
   // Register file read with write-before-read bypass from WB
   assign wb_wr = memwb_v & memwb_wr & (memwb_dst != '0);
   assign id_a  = (id_rs == '0) ? '0 : (wb_wr && memwb_dst == id_rs) ? memwb_res : rf[id_rs];
   assign id_b  = (id_rt == '0) ? '0 : (wb_wr && memwb_dst == id_rt) ? memwb_res : rf[id_rt];
   // Load-use interlock: load data is not available until the LW reaches WB
   assign ld_use = ifid_v & idex_v & (idex_op == OP_LW) & (idex_dst != '0) &
                   ((idex_dst == id_rs) | (id_use_rt & (idex_dst == id_rt)));
   // Forwarding: EX/MEM holds only ALU results (loads there are covered by the interlock)
   assign exmem_fwd = exmem_v & exmem_wr & (exmem_op != OP_LW) & (exmem_dst != '0);
   assign memwb_fwd = wb_wr;
   assign ex_a = (exmem_fwd && exmem_dst == idex_rs) ? exmem_res :
                 (memwb_fwd && memwb_dst == idex_rs) ? memwb_res : idex_a;
   assign ex_b = (exmem_fwd && exmem_dst == idex_rt) ? exmem_res :
                 (memwb_fwd && memwb_dst == idex_rt) ? memwb_res : idex_b;
   assign op2  = (idex_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL}) ? ex_b : idex_imm;
   always_comb begin
      ex_res = ex_a + op2;
      case (idex_op)
         OP_SUB, OP_SUBI: ex_res = ex_a - op2;
         OP_AND:          ex_res = ex_a & op2;
         OP_OR:           ex_res = ex_a | op2;
         OP_SLT, OP_SLTI: ex_res = XLEN'($signed(ex_a) < $signed(op2));
         OP_MUL:          ex_res = ex_a * op2;
         default: ;
      endcase
   end
   assign taken  = idex_v & (((idex_op == OP_BEQZ) & (ex_a == '0)) | ((idex_op == OP_BNEQZ) & (ex_a != '0)));
   assign target = idex_npc + PC_W'(idex_imm);
   assign imem_addr  = pc;
   assign dmem_addr  = exmem_res[DADDR_W-1:0];
   assign dmem_wdata = exmem_b;
   assign dmem_we    = exmem_v & (exmem_op == OP_SW) & ~halted;
   assign dbg_rdata  = (dbg_addr[RW-1:0] == '0) ? '0 : rf[dbg_addr[RW-1:0]];
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc        <= '0;
         halt_seen <= 1'b0;
         ifid_v    <= 1'b0;
         idex_v    <= 1'b0;
         exmem_v   <= 1'b0;
         memwb_v   <= 1'b0;
         halted    <= 1'b0;
         instret   <= '0;
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else if (!halted) begin
         // A taken branch wins over both the interlock and a younger HLT in ID
         if (taken) pc <= target;
         else if (!(ld_use || hlt_id || halt_seen)) pc <= pc + PC_W'(1);
         if (hlt_id && !taken && !ld_use) halt_seen <= 1'b1;
         if (taken || ((hlt_id || halt_seen) && !ld_use)) ifid_v <= 1'b0;
         else if (!ld_use) begin
            ifid_v   <= 1'b1;
            ifid_ir  <= imem_rdata;
            ifid_npc <= pc + PC_W'(1);
         end
         idex_v   <= ifid_v & ~ld_use & ~taken;
         idex_op  <= id_op;
         idex_rs  <= id_rs;
         idex_rt  <= id_rt;
         idex_dst <= id_dst;
         idex_wr  <= id_wr;
         idex_a   <= id_a;
         idex_b   <= id_b;
         idex_imm <= id_imm;
         idex_npc <= ifid_npc;
         exmem_v   <= idex_v;
         exmem_op  <= idex_op;
         exmem_wr  <= idex_wr;
         exmem_dst <= idex_dst;
         exmem_res <= ex_res;
         exmem_b   <= ex_b;
         memwb_v   <= exmem_v;
         memwb_wr  <= exmem_wr;
         memwb_dst <= exmem_dst;
         memwb_hlt <= exmem_op == OP_HLT;
         memwb_res <= (exmem_op == OP_LW) ? dmem_rdata : exmem_res;
         if (wb_wr) rf[memwb_dst] <= memwb_res;
         if (memwb_v) instret <= instret + 32'd1;
         if (memwb_v && memwb_hlt) halted <= 1'b1;
      end
   end
endmodule

// File: tb/tb_mips_pipe_core.sv
// tb_mips_pipe_core: directed tests for mips_pipe_core with behavioural instruction/data memories
module tb_mips_pipe_core;
   localparam logic [5:0] ADD = 6'd0, MUL = 6'd5, LW = 6'd8, SW = 6'd9, ADDI = 6'd10, SUBI = 6'd11,
                          BNEQZ = 6'd13, BEQZ = 6'd14;
   localparam logic [31:0] HLT_W = 32'hfc00_0000;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  imem_addr, dmem_addr;
   logic [31:0] imem_rdata, dmem_wdata, dmem_rdata, dbg_rdata, instret;
   logic        dmem_we, halted;
   logic [4:0]  dbg_addr = 5'd0;
   logic [31:0] imem [1024];
   logic [31:0] dmem [1024];
   int          n_chk = 0, n_fail = 0, we_cnt = 0, cyc;
   mips_pipe_core dut (
      .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata),
      .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata), .halted(halted), .instret(instret)
   );
   always #5 clk = ~clk;
   assign imem_rdata = imem[imem_addr];
   assign dmem_rdata = dmem[dmem_addr];
   always @(posedge clk) if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
   always @(negedge clk) if (dmem_we) we_cnt++;
   function automatic logic [31:0] enc_r(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
      return {op, rs, rt, rd, 11'd0};
   endfunction
   function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction
   task automatic clear_mem;
      for (int i = 0; i < 1024; i++) begin
         imem[i] = HLT_W;
         dmem[i] = 32'd0;
      end
      we_cnt = 0;
   endtask
   task automatic do_reset;
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask
   task automatic run(output int c);
      c = 0;
      while (!halted && c < 300) begin
         @(posedge clk);
         #1;
         c++;
      end
   endtask
   task automatic load_fact;
      clear_mem();
      imem[0] = enc_i(ADDI, 0, 10, 16'd5);
      imem[1] = enc_i(ADDI, 0, 2, 16'd1);
      imem[2] = enc_r(MUL, 2, 10, 2);
      imem[3] = enc_i(SUBI, 10, 10, 16'd1);
      imem[4] = enc_i(BNEQZ, 10, 0, 16'hfffd);
   endtask
   task automatic test_reset;
      clear_mem();
      do_reset();
      n_chk++; if (imem_addr !== 10'd0) begin n_fail++; $display("FAIL reset_pc: got %0d want 0", imem_addr); end
      n_chk++; if (dmem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", dmem_we); end
      n_chk++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
      n_chk++; if (instret !== 32'd0) begin n_fail++; $display("FAIL reset_instret: got %0d want 0", instret); end
   endtask
   task automatic test_forwarding;
      clear_mem();
      imem[0] = enc_i(ADDI, 0, 1, 16'd10);
      imem[1] = enc_i(ADDI, 0, 2, 16'd20);
      imem[2] = enc_r(ADD, 1, 2, 3);
      do_reset();
      run(cyc);
      n_chk++; if (cyc != 8) begin n_fail++; $display("FAIL fwd_cycles: got %0d want 8", cyc); end
      n_chk++; if (halted !== 1'b1) begin n_fail++; $display("FAIL fwd_halted: got %b want 1", halted); end
      n_chk++; if (instret !== 32'd4) begin n_fail++; $display("FAIL fwd_instret: got %0d want 4", instret); end
      dbg_addr = 5'd3; #1;
      n_chk++; if (dbg_rdata !== 32'd30) begin n_fail++; $display("FAIL fwd_r3: got %0d want 30", dbg_rdata); end
      repeat (3) @(posedge clk);
      #1;
      n_chk++; if (instret !== 32'd4) begin n_fail++; $display("FAIL fwd_frozen: got %0d want 4", instret); end
   endtask
   task automatic test_load_use;
      clear_mem();
      imem[0] = enc_i(ADDI, 0, 1, 16'd7);
      imem[1] = enc_i(SW, 0, 1, 16'd5);
      imem[2] = enc_i(LW, 0, 2, 16'd5);
      imem[3] = enc_r(ADD, 2, 2, 3);
      do_reset();
      run(cyc);
      n_chk++; if (cyc != 10) begin n_fail++; $display("FAIL lu_cycles: got %0d want 10", cyc); end
      n_chk++; if (dmem[5] !== 32'd7) begin n_fail++; $display("FAIL lu_dmem5: got %0d want 7", dmem[5]); end
      n_chk++; if (we_cnt != 1) begin n_fail++; $display("FAIL lu_we_count: got %0d want 1", we_cnt); end
      n_chk++; if (instret !== 32'd5) begin n_fail++; $display("FAIL lu_instret: got %0d want 5", instret); end
      dbg_addr = 5'd3; #1;
      n_chk++; if (dbg_rdata !== 32'd14) begin n_fail++; $display("FAIL lu_r3: got %0d want 14", dbg_rdata); end
   endtask
   task automatic test_branch_squash;
      clear_mem();
      imem[0] = enc_i(BEQZ, 0, 0, 16'd2);
      imem[1] = enc_i(ADDI, 0, 4, 16'd1);
      imem[2] = enc_i(ADDI, 0, 5, 16'd1);
      imem[3] = enc_i(ADDI, 0, 6, 16'd1);
      do_reset();
      run(cyc);
      n_chk++; if (cyc != 9) begin n_fail++; $display("FAIL br_cycles: got %0d want 9", cyc); end
      n_chk++; if (instret !== 32'd3) begin n_fail++; $display("FAIL br_instret: got %0d want 3", instret); end
      dbg_addr = 5'd4; #1;
      n_chk++; if (dbg_rdata !== 32'd0) begin n_fail++; $display("FAIL br_r4: got %0d want 0", dbg_rdata); end
      dbg_addr = 5'd5; #1;
      n_chk++; if (dbg_rdata !== 32'd0) begin n_fail++; $display("FAIL br_r5: got %0d want 0", dbg_rdata); end
      dbg_addr = 5'd6; #1;
      n_chk++; if (dbg_rdata !== 32'd1) begin n_fail++; $display("FAIL br_r6: got %0d want 1", dbg_rdata); end
   endtask
   task automatic test_loop;
      load_fact();
      do_reset();
      run(cyc);
      n_chk++; if (halted !== 1'b1) begin n_fail++; $display("FAIL loop_halted: got %b want 1", halted); end
      n_chk++; if (cyc != 30) begin n_fail++; $display("FAIL loop_cycles: got %0d want 30", cyc); end
      n_chk++; if (instret !== 32'd18) begin n_fail++; $display("FAIL loop_instret: got %0d want 18", instret); end
      dbg_addr = 5'd2; #1;
      n_chk++; if (dbg_rdata !== 32'd120) begin n_fail++; $display("FAIL loop_r2: got %0d want 120", dbg_rdata); end
   endtask
   task automatic test_reset_mid_run;
      load_fact();
      do_reset();
      repeat (12) @(posedge clk);
      do_reset();
      n_chk++; if (imem_addr !== 10'd0) begin n_fail++; $display("FAIL mid_pc: got %0d want 0", imem_addr); end
      n_chk++; if (halted !== 1'b0) begin n_fail++; $display("FAIL mid_halted: got %b want 0", halted); end
      n_chk++; if (instret !== 32'd0) begin n_fail++; $display("FAIL mid_instret: got %0d want 0", instret); end
      dbg_addr = 5'd2; #1;
      n_chk++; if (dbg_rdata !== 32'd0) begin n_fail++; $display("FAIL mid_r2: got %0d want 0", dbg_rdata); end
      dbg_addr = 5'd10; #1;
      n_chk++; if (dbg_rdata !== 32'd0) begin n_fail++; $display("FAIL mid_r10: got %0d want 0", dbg_rdata); end
      @(posedge clk);
      #1;
      run(cyc);
      n_chk++; if (cyc != 29) begin n_fail++; $display("FAIL mid_cycles: got %0d want 29", cyc); end
      n_chk++; if (instret !== 32'd18) begin n_fail++; $display("FAIL mid_instret_end: got %0d want 18", instret); end
      dbg_addr = 5'd2; #1;
      n_chk++; if (dbg_rdata !== 32'd120) begin n_fail++; $display("FAIL mid_r2_end: got %0d want 120", dbg_rdata); end
   endtask
   task automatic test_r0_undef;
      clear_mem();
      imem[0] = enc_i(ADDI, 0, 0, 16'd9);
      imem[1] = enc_i(ADDI, 0, 1, 16'd3);
      imem[2] = {6'b010101, 26'd0};
      imem[3] = enc_i(ADDI, 0, 7, 16'd1);
      do_reset();
      run(cyc);
      n_chk++; if (cyc != 7) begin n_fail++; $display("FAIL undef_cycles: got %0d want 7", cyc); end
      n_chk++; if (instret !== 32'd3) begin n_fail++; $display("FAIL undef_instret: got %0d want 3", instret); end
      dbg_addr = 5'd0; #1;
      n_chk++; if (dbg_rdata !== 32'd0) begin n_fail++; $display("FAIL r0_read: got %0d want 0", dbg_rdata); end
      dbg_addr = 5'd1; #1;
      n_chk++; if (dbg_rdata !== 32'd3) begin n_fail++; $display("FAIL undef_r1: got %0d want 3", dbg_rdata); end
      dbg_addr = 5'd7; #1;
      n_chk++; if (dbg_rdata !== 32'd0) begin n_fail++; $display("FAIL undef_r7: got %0d want 0", dbg_rdata); end
   endtask
   initial begin
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch_squash();
      test_loop();
      test_reset_mid_run();
      test_r0_undef();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
